// File: rtl/button_pkg.sv
// Shared defaults for the debounced button bank: channel count, integrator
// thresholds and the long-press / auto-repeat timing.
package button_pkg;
    localparam int DEF_N          = 4;
    localparam int DEF_CW         = 4;
    localparam int DEF_HI_TH      = 12;
    localparam int DEF_LO_TH      = 4;
    localparam int DEF_HW         = 8;
    localparam int DEF_LONG_TICKS = 200;
    localparam int DEF_REP_TICKS  = 50;
endpackage

// File: rtl/button_chan.sv
// One button channel: 2-flop synchronizer, saturating integrator with hysteresis,
// edge pulses, toggle/momentary press output and long-press / auto-repeat pulses.
module button_chan
    import button_pkg::*;
#(
    parameter int CW         = DEF_CW,
    parameter int HI_TH      = DEF_HI_TH,
    parameter int LO_TH      = DEF_LO_TH,
    parameter int HW         = DEF_HW,
    parameter int LONG_TICKS = DEF_LONG_TICKS,
    parameter int REP_TICKS  = DEF_REP_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_in,
    input  logic mode,
    output logic level,
    output logic press,
    output logic rise,
    output logic fall,
    output logic long_pulse
);
    localparam int CMAX = (1 << CW) - 1;

    if (!(LO_TH < HI_TH && HI_TH <= CMAX && LONG_TICKS >= 1 &&
          LONG_TICKS < (1 << HW) && REP_TICKS >= 0 && REP_TICKS <= LONG_TICKS)) begin : g_param_check
        $error("button_chan: illegal threshold or timing parameters");
    end

    localparam logic [CW-1:0] CMAX_C   = CW'(CMAX);
    localparam logic [CW-1:0] HI_C     = CW'(HI_TH);
    localparam logic [CW-1:0] LO_C     = CW'(LO_TH);
    localparam logic [HW-1:0] HMAX_C   = {HW{1'b1}};
    localparam logic [HW-1:0] LONG_C   = HW'(LONG_TICKS);
    localparam logic [HW-1:0] RELOAD_C = HW'(LONG_TICKS - REP_TICKS);

    logic          s1_q, s2_q;
    logic [CW-1:0] count_q, count_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          long_q, long_d;
    logic [HW-1:0] hold_q, hold_d, hold_inc;

    always_comb begin
        count_d  = count_q;
        level_d  = level_q;
        hold_d   = hold_q;
        long_d   = 1'b0;
        hold_inc = (hold_q == HMAX_C) ? hold_q : hold_q + 1'b1;

        if (tick) begin
            if (s2_q) begin
                if (count_q != CMAX_C) count_d = count_q + 1'b1;
            end else begin
                if (count_q != '0) count_d = count_q - 1'b1;
            end
            if (count_d > HI_C)      level_d = 1'b1;
            else if (count_d < LO_C) level_d = 1'b0;
        end

        rise_d  = level_d & ~level_q;
        fall_d  = ~level_d & level_q;
        press_d = mode ? (press_q ^ rise_d) : level_d;

        // Only count ticks while held both before and after this edge, so the
        // fall edge clears the counter and can never emit a long pulse.
        if (!(level_q && level_d)) begin
            hold_d = '0;
        end else if (tick) begin
            hold_d = hold_inc;
            if (hold_q != HMAX_C && hold_inc == LONG_C) begin
                long_d = 1'b1;
                if (REP_TICKS > 0) hold_d = RELOAD_C;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            count_q <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            long_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            s1_q    <= btn_in;
            s2_q    <= s1_q;
            count_q <= count_d;
            level_q <= level_d;
            press_q <= press_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            long_q  <= long_d;
            hold_q  <= hold_d;
        end
    end

    assign level      = level_q;
    assign press      = press_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign long_pulse = long_q;
endmodule

// File: rtl/button_bank.sv
// Bank of N independent debounced button channels; pure wiring around button_chan.
module button_bank
    import button_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int CW         = DEF_CW,
    parameter int HI_TH      = DEF_HI_TH,
    parameter int LO_TH      = DEF_LO_TH,
    parameter int HW         = DEF_HW,
    parameter int LONG_TICKS = DEF_LONG_TICKS,
    parameter int REP_TICKS  = DEF_REP_TICKS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic [N-1:0] in,
    input  logic [N-1:0] mode,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] long
);
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            button_chan #(
                .CW        (CW),
                .HI_TH     (HI_TH),
                .LO_TH     (LO_TH),
                .HW        (HW),
                .LONG_TICKS(LONG_TICKS),
                .REP_TICKS (REP_TICKS)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .tick      (tick),
                .btn_in    (in[gi]),
                .mode      (mode[gi]),
                .level     (level[gi]),
                .press     (press[gi]),
                .rise      (rise[gi]),
                .fall      (fall[gi]),
                .long_pulse(long[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_button_bank.sv
// Self-checking bench for button_bank: directed scenarios plus randomized
// stimulus against a tick-counting behavioural model.
module tb_button_bank;
    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;
    localparam int HI   = 12;
    localparam int LO   = 4;
    localparam int HW   = 8;
    localparam int LONG = 200;
    localparam int REP  = 50;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tick = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_mode = '0;
    logic [N-1:0] level, press, rise, fall, lng;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    button_bank #(
        .N(N), .CW(CW), .HI_TH(HI), .LO_TH(LO), .HW(HW),
        .LONG_TICKS(LONG), .REP_TICKS(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .in(btn_in), .mode(btn_mode),
        .level(level), .press(press), .rise(rise), .fall(fall), .long(lng)
    );

    // Reference model: integrator as a clamped integer, long pulses from the
    // number of ticks held since the rising edge (LONG, LONG+REP, LONG+2REP...).
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_press = '0;
    logic [N-1:0] m_rise = '0, m_fall = '0, m_long = '0;
    int m_cnt [N];
    int m_held[N];

    initial begin
        for (int c = 0; c < N; c++) begin
            m_cnt[c]  = 0;
            m_held[c] = 0;
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            int nc;
            int nh;
            bit nl;
            bit lp;
            nc = m_cnt[c];
            nl = m_lvl[c];
            nh = m_held[c];
            lp = 1'b0;
            if (!rst_n) begin
                m_s1[c] <= 1'b0; m_s2[c] <= 1'b0; m_cnt[c] <= 0; m_held[c] <= 0;
                m_lvl[c] <= 1'b0; m_press[c] <= 1'b0; m_rise[c] <= 1'b0;
                m_fall[c] <= 1'b0; m_long[c] <= 1'b0;
            end else begin
                if (tick) nc = m_s2[c] ? ((m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX)
                                       : ((m_cnt[c] > 0) ? m_cnt[c] - 1 : 0);
                if (nc > HI) nl = 1'b1;
                else if (nc < LO) nl = 1'b0;
                if (m_lvl[c] && nl) begin
                    if (tick) begin
                        nh = m_held[c] + 1;
                        lp = (nh == LONG) || (REP > 0 && nh > LONG && ((nh - LONG) % REP) == 0);
                    end
                end else begin
                    nh = 0;
                end
                m_s1[c]    <= btn_in[c];
                m_s2[c]    <= m_s1[c];
                m_cnt[c]   <= nc;
                m_held[c]  <= nh;
                m_lvl[c]   <= nl;
                m_rise[c]  <= nl && !m_lvl[c];
                m_fall[c]  <= !nl && m_lvl[c];
                m_press[c] <= btn_mode[c] ? (m_press[c] ^ (nl && !m_lvl[c])) : nl;
                m_long[c]  <= lp;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        btn_in = '0;
        tick   = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        btn_mode = '0;
        btn_in   = '1;
        tick     = 1'b0;
        rst_n    = 1'b0;
        step();
        step();
        n_cmp++; if (level !== '0) begin n_mis++; $display("FAIL reset_level: got %b expected 0000", level); end
        n_cmp++; if (press !== '0) begin n_mis++; $display("FAIL reset_press: got %b expected 0000", press); end
        n_cmp++; if (rise  !== '0) begin n_mis++; $display("FAIL reset_rise: got %b expected 0000", rise); end
        n_cmp++; if (fall  !== '0) begin n_mis++; $display("FAIL reset_fall: got %b expected 0000", fall); end
        n_cmp++; if (lng   !== '0) begin n_mis++; $display("FAIL reset_long: got %b expected 0000", lng); end
        $display("test_reset: outputs after reset level=%b press=%b", level, press);
    endtask

    task automatic test_latency();
        int falls;
        do_reset();
        btn_mode  = 4'b0001;
        btn_in[0] = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            n_cmp++; if (level[0] !== (e >= 15)) begin n_mis++; $display("FAIL latency_level e=%0d: got %b expected %b", e, level[0], e >= 15); end
            n_cmp++; if (rise[0] !== (e == 15)) begin n_mis++; $display("FAIL latency_rise e=%0d: got %b expected %b", e, rise[0], e == 15); end
            n_cmp++; if (press[0] !== (e >= 15)) begin n_mis++; $display("FAIL latency_press e=%0d: got %b expected %b", e, press[0], e >= 15); end
        end
        repeat (10) step();
        btn_in[0] = 1'b0;
        falls = 0;
        for (int j = 1; j <= 40; j++) begin
            step();
            if (fall[0] === 1'b1) falls++;
        end
        n_cmp++; if (falls != 1) begin n_mis++; $display("FAIL latency_fall_count: got %0d expected 1", falls); end
        n_cmp++; if (level[0] !== 1'b0) begin n_mis++; $display("FAIL latency_release_level: got %b expected 0", level[0]); end
        n_cmp++; if (press[0] !== 1'b1) begin n_mis++; $display("FAIL latency_toggle_hold: got %b expected 1", press[0]); end
        $display("test_latency: level/rise at edge 15, toggle press=%b after release", press[0]);
    endtask

    task automatic test_bounce();
        do_reset();
        btn_mode = '0;
        for (int i = 0; i < 100; i++) begin
            btn_in[1] = ((i % 2) == 0);
            step();
            n_cmp++;
            if ({level[1], rise[1], lng[1]} !== 3'b000) begin
                n_mis++; $display("FAIL bounce i=%0d: got level/rise/long=%b%b%b expected 000", i, level[1], rise[1], lng[1]);
            end
        end
        btn_in[1] = 1'b0;
        repeat (10) step();
        n_cmp++; if (level[1] !== 1'b0) begin n_mis++; $display("FAIL bounce_settle: got %b expected 0", level[1]); end
        $display("test_bounce: 100 clk of bounce, level=%b", level[1]);
    endtask

    task automatic test_long();
        do_reset();
        btn_mode  = '0;
        btn_in[2] = 1'b1;
        for (int e = 1; e <= 330; e++) begin
            step();
            n_cmp++;
            if (lng[2] !== (e == 215 || e == 265 || e == 315)) begin
                n_mis++; $display("FAIL long_pulse e=%0d: got %b expected %b", e, lng[2], e == 215 || e == 265 || e == 315);
            end
        end
        btn_in[2] = 1'b0;
        for (int j = 1; j <= 100; j++) begin
            step();
            n_cmp++; if (fall[2] !== (j == 14)) begin n_mis++; $display("FAIL long_fall j=%0d: got %b expected %b", j, fall[2], j == 14); end
            n_cmp++; if (lng[2] !== 1'b0) begin n_mis++; $display("FAIL long_after_release j=%0d: got %b expected 0", j, lng[2]); end
        end
        $display("test_long: pulses at edges 215/265/315, fall 14 edges after release");
    endtask

    task automatic test_toggle();
        logic [2:0] phase [6];
        phase[0] = 3'b111; phase[1] = 3'b010; phase[2] = 3'b101;
        phase[3] = 3'b000; phase[4] = 3'b111; phase[5] = 3'b010;
        do_reset();
        btn_mode = 4'b1000;
        for (int p = 0; p < 6; p++) begin
            btn_in[3] = phase[p][2];
            repeat (30) step();
            n_cmp++; if (press[3] !== phase[p][1]) begin n_mis++; $display("FAIL toggle_press p=%0d: got %b expected %b", p, press[3], phase[p][1]); end
            n_cmp++; if (level[3] !== phase[p][0]) begin n_mis++; $display("FAIL toggle_level p=%0d: got %b expected %b", p, level[3], phase[p][0]); end
        end
        btn_mode[3] = 1'b0;
        step();
        n_cmp++; if (press[3] !== 1'b0) begin n_mis++; $display("FAIL toggle_to_momentary: got %b expected 0", press[3]); end
        btn_in[3] = 1'b1;
        repeat (30) step();
        n_cmp++; if (press[3] !== 1'b1) begin n_mis++; $display("FAIL momentary_pressed: got %b expected 1", press[3]); end
        btn_mode[3] = 1'b1;
        step();
        n_cmp++; if (press[3] !== 1'b1) begin n_mis++; $display("FAIL momentary_to_toggle: got %b expected 1", press[3]); end
        btn_in[3] = 1'b0;
        repeat (30) step();
        n_cmp++; if (press[3] !== 1'b1) begin n_mis++; $display("FAIL toggle_release_hold: got %b expected 1", press[3]); end
        $display("test_toggle: toggle sequence and mode switches done, press=%b", press[3]);
    endtask

    task automatic test_simultaneous();
        do_reset();
        btn_mode = '0;
        btn_in   = '1;
        for (int e = 1; e <= 16; e++) begin
            step();
            n_cmp++;
            if (rise !== ((e == 15) ? 4'b1111 : 4'b0000)) begin
                n_mis++; $display("FAIL simultaneous_rise e=%0d: got %b expected %b", e, rise, (e == 15) ? 4'b1111 : 4'b0000);
            end
        end
        $display("test_simultaneous: all channels rose together, level=%b", level);
    endtask

    task automatic test_tick_div();
        do_reset();
        btn_mode  = 4'b0001;
        btn_in[0] = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            tick = ((e % 4) == 0);
            step();
            n_cmp++; if (level[0] !== (e >= 52)) begin n_mis++; $display("FAIL tickdiv_level e=%0d: got %b expected %b", e, level[0], e >= 52); end
            n_cmp++; if (rise[0] !== (e == 52)) begin n_mis++; $display("FAIL tickdiv_rise e=%0d: got %b expected %b", e, rise[0], e == 52); end
        end
        tick  = 1'b0;
        rst_n = 1'b0;
        step();
        n_cmp++;
        if ({level, press, rise, fall, lng} !== '0) begin
            n_mis++; $display("FAIL midpress_reset: got level=%b press=%b rise=%b fall=%b long=%b expected all 0", level, press, rise, fall, lng);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick = ((k % 4) == 0);
            step();
            n_cmp++; if ({level[0], rise[0], lng[0]} !== 3'b000) begin n_mis++; $display("FAIL restart k=%0d: got level/rise/long=%b%b%b expected 000", k, level[0], rise[0], lng[0]); end
        end
        $display("test_tick_div: rise at edge 52 with tick every 4th clk, reset cleared outputs");
    endtask

    task automatic test_random();
        int dur[N];
        int r;
        int fails_before;
        do_reset();
        btn_mode = '0;
        for (int c = 0; c < N; c++) dur[c] = $urandom_range(1, 40);
        fails_before = n_mis;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (dur[c] == 0) begin
                    btn_in[c] = ~btn_in[c];
                    r = $urandom_range(0, 9);
                    dur[c] = (r < 3) ? $urandom_range(1, 3) : (r < 9) ? $urandom_range(10, 40) : $urandom_range(260, 420);
                end else begin
                    dur[c]--;
                end
                if ($urandom_range(0, 63) == 0) btn_mode[c] = ~btn_mode[c];
            end
            tick  = ($urandom_range(0, 7) != 0);
            rst_n = ($urandom_range(0, 999) != 0);
            step();
            n_cmp++; if (level !== m_lvl)   begin n_mis++; $display("FAIL rand_level cyc=%0d: got %b expected %b", cyc, level, m_lvl); end
            n_cmp++; if (press !== m_press) begin n_mis++; $display("FAIL rand_press cyc=%0d: got %b expected %b", cyc, press, m_press); end
            n_cmp++; if (rise  !== m_rise)  begin n_mis++; $display("FAIL rand_rise cyc=%0d: got %b expected %b", cyc, rise, m_rise); end
            n_cmp++; if (fall  !== m_fall)  begin n_mis++; $display("FAIL rand_fall cyc=%0d: got %b expected %b", cyc, fall, m_fall); end
            n_cmp++; if (lng   !== m_long)  begin n_mis++; $display("FAIL rand_long cyc=%0d: got %b expected %b", cyc, lng, m_long); end
        end
        rst_n = 1'b1;
        $display("test_random: 4000 cycles against model, %0d new mismatches", n_mis - fails_before);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bounce();
        test_long();
        test_toggle();
        test_simultaneous();
        test_tick_div();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
